// File: rtl/axis_mac_accum_if.sv
// AXI-Stream bundle for axis_mac_accum; W sets tdata width, tuser carries status flags.
interface axis_mac_accum_if #(
  parameter int W = 32
) ();
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;
  logic [1:0]   tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_mac_accum.sv
// Streaming int8 dual-MAC with saturating per-packet accumulation, one result beat per packet.
// Optional `ACC_RELU_EN clamps negative results to zero and flags it on tuser[1].
module axis_mac_accum #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  axis_mac_accum_if.slave  s_axis,
  axis_mac_accum_if.master m_axis
);

  logic                        en;
  logic                        p_valid_q, p_valid_d;
  logic                        p_last_q, p_last_d;
  logic signed [16:0]          p_q, p_d;
  logic signed [15:0]          prod0, prod1;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                        first_q, first_d;
  logic                        sat_q, sat_d;
  logic signed [ACC_WIDTH-1:0] m_data_q, m_data_d;
  logic                        m_valid_q, m_valid_d;
  logic                        m_last_q, m_last_d;
  logic [1:0]                  m_user_q, m_user_d;

  logic signed [ACC_WIDTH:0]   base, pext, sum;
  logic signed [ACC_WIDTH-1:0] clamped, result;
  logic                        ovf, sat_now, relu;

  // Stage P and A advance together; a held result freezes the whole pipe.
  assign en            = !(m_valid_q && !m_axis.tready);
  assign s_axis.tready = en && rst_n;

  always_comb begin
    prod0     = $signed(s_axis.tdata[7:0])   * $signed(s_axis.tdata[15:8]);
    prod1     = $signed(s_axis.tdata[23:16]) * $signed(s_axis.tdata[31:24]);
    p_valid_d = p_valid_q;
    p_last_d  = p_last_q;
    p_d       = p_q;
    if (en) begin
      p_valid_d = s_axis.tvalid && s_axis.tready;
      p_last_d  = s_axis.tlast;
      p_d       = {prod0[15], prod0} + {prod1[15], prod1};
    end
  end

  always_comb begin
    base    = first_q ? '0 : (ACC_WIDTH+1)'(acc_q);
    pext    = (ACC_WIDTH+1)'(p_q);
    sum     = base + pext;
    // One guard bit suffices: |p| is far below the accumulator range.
    ovf     = sum[ACC_WIDTH] != sum[ACC_WIDTH-1];
    clamped = sum[ACC_WIDTH-1:0];
    if (ovf) clamped = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                      : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    sat_now = ovf || (sat_q && !first_q);
    result  = clamped;
    relu    = 1'b0;
`ifdef ACC_RELU_EN
    if (clamped[ACC_WIDTH-1]) begin
      result = '0;
      relu   = 1'b1;
    end
`endif
  end

  always_comb begin
    acc_d     = acc_q;
    first_d   = first_q;
    sat_d     = sat_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_user_d  = m_user_q;
    if (m_valid_q && m_axis.tready) m_valid_d = 1'b0;
    if (en && p_valid_q) begin
      if (p_last_q) begin
        m_data_d  = result;
        m_valid_d = 1'b1;
        m_last_d  = 1'b1;
        m_user_d  = {relu, sat_now};
        acc_d     = '0;
        first_d   = 1'b1;
        sat_d     = 1'b0;
      end else begin
        acc_d   = clamped;
        first_d = 1'b0;
        sat_d   = sat_now;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid_q <= 1'b0;
      p_last_q  <= 1'b0;
      p_q       <= '0;
      acc_q     <= '0;
      first_q   <= 1'b1;
      sat_q     <= 1'b0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_user_q  <= '0;
    end else begin
      p_valid_q <= p_valid_d;
      p_last_q  <= p_last_d;
      p_q       <= p_d;
      acc_q     <= acc_d;
      first_q   <= first_d;
      sat_q     <= sat_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_user_q  <= m_user_d;
    end
  end

  assign m_axis.tdata  = m_data_q;
  assign m_axis.tvalid = m_valid_q;
  assign m_axis.tlast  = m_last_q;
  assign m_axis.tuser  = m_user_q;

endmodule

// File: tb/tb_axis_mac_accum.sv
// Self-checking bench for axis_mac_accum: constant vectors, directed corner sequences, random packets vs. model.
module tb_axis_mac_accum;
  localparam int ACC_W = 18;
  localparam longint MAXV = (64'sd1 <<< (ACC_W-1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (ACC_W-1));
`ifdef ACC_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axis_mac_accum_if #(.W(32))    s_if ();
  axis_mac_accum_if #(.W(ACC_W)) m_if ();
  assign s_if.tuser = '0;

  axis_mac_accum #(.DATA_WIDTH(32), .ACC_WIDTH(ACC_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_axis (s_if),
    .m_axis (m_if)
  );

  int ncmp = 0;
  int nerr = 0;
  int nrecv = 0;
  int rdy_mode = 0;   // 0: always ready, 1: held low, 2: random
  longint last_data = 0;
  logic [1:0] last_user = '0;

  typedef struct { longint data; logic [1:0] user; } res_t;
  res_t expq[$];
  longint macc = 0;
  bit mfirst = 1'b1;
  bit msat = 1'b0;

  task automatic check(input string nm, input logic signed [63:0] got, input logic signed [63:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    ncmp++;
    nerr++;
    $display("FAIL %s: bound expired (t=%0t)", nm, $time);
  endtask

  // Reference: per-packet running sum clamped to the accumulator range after every beat.
  function automatic void model_beat(input logic [31:0] d, input logic last);
    byte a0, w0, a1, w1;
    longint s;
    bit sat;
    res_t r;
    a0 = d[7:0]; w0 = d[15:8]; a1 = d[23:16]; w1 = d[31:24];
    s = (mfirst ? 0 : macc) + longint'(a0) * longint'(w0) + longint'(a1) * longint'(w1);
    sat = mfirst ? 1'b0 : msat;
    if (s > MAXV) begin s = MAXV; sat = 1'b1; end
    else if (s < MINV) begin s = MINV; sat = 1'b1; end
    if (last) begin
      r.data = s;
      r.user = {1'b0, sat};
      if (RELU && s < 0) begin r.data = 0; r.user[1] = 1'b1; end
      expq.push_back(r);
      macc = 0; mfirst = 1'b1; msat = 1'b0;
    end else begin
      macc = s; mfirst = 1'b0; msat = sat;
    end
  endfunction

  function automatic void model_reset();
    macc = 0; mfirst = 1'b1; msat = 1'b0;
    expq.delete();
  endfunction

  initial m_if.tready = 1'b1;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_if.tready = 1'b1;
      1:       m_if.tready = 1'b0;
      default: m_if.tready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Output monitor: in-order scoreboard plus hold-stability while stalled.
  logic              stall_prev = 1'b0;
  logic [ACC_W-1:0]  held_data;
  logic [1:0]        held_user;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && m_if.tvalid) begin
        check("hold_data", m_if.tdata, held_data);
        check("hold_user", m_if.tuser, held_user);
      end
      if (m_if.tvalid) begin
        if (m_if.tready) begin
          if (expq.size() == 0) begin
            fail_now("unexpected_result");
          end else begin
            res_t e;
            e = expq.pop_front();
            check("result_data", $signed(m_if.tdata), e.data);
            check("result_user", m_if.tuser, e.user);
            check("result_tlast", m_if.tlast, 1);
          end
          last_data = $signed(m_if.tdata);
          last_user = m_if.tuser;
          nrecv++;
        end
        stall_prev = !m_if.tready;
        held_data  = m_if.tdata;
        held_user  = m_if.tuser;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic send_beat(input logic [31:0] d, input logic last);
    int n = 0;
    bit ok = 1'b0;
    s_if.tdata  = d;
    s_if.tlast  = last;
    s_if.tvalid = 1'b1;
    while (!ok && n < 300) begin
      @(negedge clk);
      ok = s_if.tready;
      @(posedge clk);
      n++;
    end
    #1;
    s_if.tvalid = 1'b0;
    if (!ok) fail_now("input_accept");
    else model_beat(d, last);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((expq.size() != 0 || m_if.tvalid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) fail_now("drain");
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_m_tvalid", m_if.tvalid, 0);
    check("rst_m_tdata", m_if.tdata, 0);
    check("rst_m_tlast", m_if.tlast, 0);
    check("rst_m_tuser", m_if.tuser, 0);
    check("rst_s_tready", s_if.tready, 0);
  endtask

  typedef struct {
    logic [31:0]              d;
    logic signed [ACC_W-1:0]  exp;
    logic [1:0]               user;
  } vec_t;
  vec_t tbl[6];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int base_recv;
    tbl[0] = '{32'h02030405, 26, 2'b00};
    tbl[1] = '{32'h80808080, 32768, 2'b00};
    tbl[2] = '{32'h7F7F7F7F, 32258, 2'b00};
    tbl[3] = '{32'h7F807F80, RELU ? 0 : -32512, RELU ? 2'b10 : 2'b00};
    tbl[4] = '{32'h00000000, 0, 2'b00};
    tbl[5] = '{32'h01FF01FF, RELU ? 0 : -2, RELU ? 2'b10 : 2'b00};

    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-beat vectors with 2-cycle latency check.
    for (int i = 0; i < 6; i++) begin
      send_beat(tbl[i].d, 1'b1);
      @(negedge clk);
      check("latency_early", m_if.tvalid, 0);
      @(negedge clk);
      check("latency_valid", m_if.tvalid, 1);
      check("vec_data", $signed(m_if.tdata), tbl[i].exp);
      check("vec_user", m_if.tuser, tbl[i].user);
      check("vec_tlast", m_if.tlast, 1);
      @(posedge clk); #1;
    end

    // Negative products across three beats.
    send_beat(32'h80808080, 1'b0);
    send_beat(32'h80808080, 1'b0);
    send_beat(32'h80808080, 1'b1);
    wait_drain();
    check("neg3_data", last_data, 98304);
    check("neg3_user", last_user, 0);

    // Saturation then clean packet.
    for (int i = 0; i < 5; i++) send_beat(32'h7F7F7F7F, i == 4);
    wait_drain();
    check("sat_data", last_data, 131071);
    check("sat_user", last_user, 1);
    send_beat(32'h02030405, 1'b1);
    wait_drain();
    check("after_sat_data", last_data, 26);
    check("after_sat_user", last_user, 0);

    // Backpressure with back-to-back packets.
    base_recv = nrecv;
    rdy_mode = 1;
    m_if.tready = 1'b0;
    fork
      begin
        send_beat(32'h02030405, 1'b1);
        send_beat(32'h01010101, 1'b0);
        send_beat(32'h01010101, 1'b1);
      end
      begin
        int n = 0;
        while (!m_if.tvalid && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) fail_now("bp_result_wait");
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("bp_s_tready_low", s_if.tready, 0);
          check("bp_first_held", $signed(m_if.tdata), 26);
        end
        rdy_mode = 0;
      end
    join
    wait_drain();
    check("bp_count", nrecv - base_recv, 2);
    check("bp_last", last_data, 4);

    // Reset mid-packet discards the partial sum.
    send_beat(32'h11111111, 1'b0);
    send_beat(32'h22222222, 1'b0);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset_outputs();
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    base_recv = nrecv;
    send_beat(32'h02030405, 1'b1);
    wait_drain();
    repeat (4) @(posedge clk);
    #1;
    check("rst_count", nrecv - base_recv, 1);
    check("rst_result", last_data, 26);

    // Random packets with random downstream backpressure.
    rdy_mode = 2;
    base_recv = nrecv;
    for (int pk = 0; pk < 60; pk++) begin
      int len;
      len = $urandom_range(1, 8);
      for (int b = 0; b < len; b++) begin
        logic [31:0] d;
        d = ($urandom_range(0, 2) == 0) ? (($urandom_range(0, 1) == 0) ? 32'h7F7F7F7F : 32'h7F807F80)
                                        : $urandom;
        send_beat(d, b == len - 1);
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      end
    end
    rdy_mode = 0;
    wait_drain();
    check("rand_count", nrecv - base_recv, 60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
